// File: rtl/target_boot_supervisor.sv
// Power-cycle sequencer and boot/heartbeat supervisor for the target power control stage.
// Define TARGET_BOOT_WATCHDOG_EN to build the READY heartbeat watchdog.
module target_boot_supervisor #(
  parameter int unsigned POWER_CYCLES    = 4800200,
  parameter int unsigned BOOT_TIMEOUT    = 48000000,
  parameter int unsigned WATCHDOG_CYCLES = 24000000,
  parameter int unsigned MAX_RETRIES     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reset_req,
  input  logic       target_alive,
  output logic       trigger,
  output logic       busy,
  output logic       target_ready,
  output logic       boot_fail,
  output logic [3:0] retry_count,
  output logic       watchdog_bite
);

  typedef enum logic [2:0] {
    S_TRIGGER,
    S_POWER_WAIT,
    S_BOOT_WAIT,
    S_READY,
    S_FAILED
  } state_t;

  localparam logic [31:0] POWER_LAST  = 32'(POWER_CYCLES - 1);
  localparam logic [31:0] BOOT_LAST   = 32'(BOOT_TIMEOUT - 1);
  localparam logic [3:0]  RETRY_LIMIT = 4'(MAX_RETRIES);
`ifdef TARGET_BOOT_WATCHDOG_EN
  localparam logic [31:0] WD_LIMIT    = 32'(WATCHDOG_CYCLES);
  localparam logic [31:0] WD_LAST     = 32'(WATCHDOG_CYCLES - 1);
`endif

  state_t      state, state_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic [3:0]  retry_nxt, retry_inc;
  logic        alive_meta, alive_sync, alive_prev, act_edge;
`ifdef TARGET_BOOT_WATCHDOG_EN
  logic        bite_nxt;
`endif

  assign retry_inc = (retry_count == 4'hF) ? retry_count : retry_count + 4'd1;

  // One counter serves power wait, boot wait and (when built) the READY watchdog.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt == '1) ? cnt : cnt + 32'd1;
    retry_nxt = retry_count;
`ifdef TARGET_BOOT_WATCHDOG_EN
    bite_nxt  = 1'b0;
`endif
    case (state)
      S_TRIGGER: begin
        state_nxt = S_POWER_WAIT;
        cnt_nxt   = '0;
      end
      S_POWER_WAIT: begin
        if (cnt >= POWER_LAST) begin
          state_nxt = S_BOOT_WAIT;
          cnt_nxt   = '0;
        end
      end
      S_BOOT_WAIT: begin
        if (act_edge) begin
          state_nxt = S_READY;
          cnt_nxt   = '0;
        end else if (cnt >= BOOT_LAST) begin
          cnt_nxt   = '0;
          retry_nxt = retry_inc;
          state_nxt = (retry_inc == RETRY_LIMIT) ? S_FAILED : S_TRIGGER;
        end
      end
      S_READY: begin
        if (reset_req) begin
          state_nxt = S_TRIGGER;
          retry_nxt = '0;
          cnt_nxt   = '0;
        end
`ifdef TARGET_BOOT_WATCHDOG_EN
        // Bite is pulsed when the count reaches the limit; the trigger follows one cycle later.
        else if (cnt >= WD_LIMIT) begin
          state_nxt = S_TRIGGER;
          cnt_nxt   = '0;
        end else if (act_edge) begin
          cnt_nxt = '0;
        end else if (cnt == WD_LAST) begin
          bite_nxt  = 1'b1;
          retry_nxt = '0;
        end
`else
        else begin
          cnt_nxt = cnt;
        end
`endif
      end
      S_FAILED: begin
        cnt_nxt = cnt;
        if (reset_req) begin
          state_nxt = S_TRIGGER;
          retry_nxt = '0;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_POWER_WAIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alive_meta    <= 1'b0;
      alive_sync    <= 1'b0;
      alive_prev    <= 1'b0;
      act_edge      <= 1'b0;
      state         <= S_POWER_WAIT;
      cnt           <= '0;
      retry_count   <= '0;
      trigger       <= 1'b0;
      busy          <= 1'b1;
      target_ready  <= 1'b0;
      boot_fail     <= 1'b0;
`ifdef TARGET_BOOT_WATCHDOG_EN
      watchdog_bite <= 1'b0;
`endif
    end else begin
      alive_meta    <= target_alive;
      alive_sync    <= alive_meta;
      alive_prev    <= alive_sync;
      act_edge      <= alive_sync ^ alive_prev;
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      retry_count   <= retry_nxt;
      trigger       <= (state_nxt == S_TRIGGER);
      busy          <= (state_nxt inside {S_TRIGGER, S_POWER_WAIT, S_BOOT_WAIT});
      target_ready  <= (state_nxt == S_READY);
      boot_fail     <= (state_nxt == S_FAILED);
`ifdef TARGET_BOOT_WATCHDOG_EN
      watchdog_bite <= bite_nxt;
`endif
    end
  end

`ifndef TARGET_BOOT_WATCHDOG_EN
  assign watchdog_bite = 1'b0;
`endif

endmodule

// File: doc/target_boot_supervisor.md
# target_boot_supervisor

Sequences target power cycles and decides when the target has booted. Sits directly upstream of the target power control stage and drives its `trigger` input. On host request, boot timeout or heartbeat loss, it issues a one-cycle trigger, waits out the power cycle, then waits for target activity. It reports ready/fail status and a retry count to the host logic.

## Interface
Parameters:
- `POWER_CYCLES`, 4800200: cycles from trigger until the target power feed is back on. Must be ≥ downstream `RESET_CYCLES` + `GUARD_CYCLES` + 1.
- `BOOT_TIMEOUT`, 48000000: cycles allowed in boot wait for the first activity edge.
- `WATCHDOG_CYCLES`, 24000000: maximum gap between activity edges while ready.
- `MAX_RETRIES`, 3: consecutive boot timeouts tolerated before declaring failure. Range 1..15.

Ports:
- `clk`, in, 1: fast clock.
- `rst`, in, 1: synchronous, active-high reset.
- `reset_req`, in, 1: host request for a power cycle, sampled each cycle.
- `target_alive`, in, 1: asynchronous target activity/heartbeat pin.
- `trigger`, out, 1: to the power control stage; high for exactly one cycle per power cycle.
- `busy`, out, 1: high while a power cycle or boot wait is in progress.
- `target_ready`, out, 1: target booted and heartbeat healthy.
- `boot_fail`, out, 1: retries exhausted.
- `retry_count`, out, 4: boot timeouts since the last host request.
- `watchdog_bite`, out, 1: one-cycle pulse when the watchdog forces a power cycle.

## Operation
- `target_alive` passes through a 2-FF synchronizer. An activity edge is any transition of the synchronized value, detected against one further registered copy.
- States and transitions:
  - TRIGGER: `trigger` = 1. Always goes to POWER_WAIT next cycle, with the counter cleared.
  - POWER_WAIT: counts. Goes to BOOT_WAIT after exactly `POWER_CYCLES` cycles in this state. Activity edges are ignored.
  - BOOT_WAIT: on an activity edge, goes to READY.
    - If `BOOT_TIMEOUT` cycles pass with no edge, `retry_count` increments.
    - If the new count equals `MAX_RETRIES`, go to FAILED; otherwise go to TRIGGER.
  - READY: the watchdog counter clears on every activity edge.
    - When it reaches `WATCHDOG_CYCLES`: pulse `watchdog_bite`, clear `retry_count`, go to TRIGGER.
  - FAILED: holds until `reset_req`.
- `reset_req` in READY or FAILED goes to TRIGGER and clears `retry_count`. It is ignored in TRIGGER, POWER_WAIT and BOOT_WAIT (no queuing).
- `reset_req` and watchdog expiry in the same cycle: a single TRIGGER, and `watchdog_bite` is not pulsed.
- Activity edge and boot timeout in the same cycle: the edge wins and the state goes to READY.
- Counters are 32-bit unsigned and saturate; they never wrap.
- `busy` = TRIGGER | POWER_WAIT | BOOT_WAIT. `target_ready` = READY. `boot_fail` = FAILED. All outputs are registered.

## Timing
- Reset values:
  - state POWER_WAIT, counter 0.
  - `trigger` 0, `busy` 1, `target_ready` 0, `boot_fail` 0, `retry_count` 0, `watchdog_bite` 0.
- After reset no trigger is issued, because the downstream stage powers up on its own reset. Boot wait starts after `POWER_CYCLES`.
- `reset_req` high at cycle n in READY: `trigger` high in cycle n+1, POWER_WAIT from n+2, BOOT_WAIT from n+2+`POWER_CYCLES`.
- A `target_alive` toggle at cycle n is seen as an edge at n+3. The state change is visible at n+4.
- Watchdog: with the last edge seen at cycle m, the bite fires when the count reaches `WATCHDOG_CYCLES`. `watchdog_bite` is high at cycle m+`WATCHDOG_CYCLES`+1, and `trigger` is high on the next cycle.
- `rst` mid-operation (any state) returns to reset values on the next edge. A `trigger` in flight is dropped.

## Configuration
- `TARGET_BOOT_WATCHDOG_EN` defined: READY watchdog behaves as specified.
- Not defined: READY is left only by `reset_req`. `watchdog_bite` is tied 0 and the watchdog counter is not built.

## Test plan
- Reset, params POWER_CYCLES=10, BOOT_TIMEOUT=20, toggle `target_alive` at cycle 15 after reset -> `busy`=1 through boot wait, `target_ready`=1, `trigger` never pulsed.
- In READY, `reset_req` one cycle -> exactly one `trigger` cycle, `busy`=1 for 1+10 cycles plus boot wait, `retry_count`=0.
- MAX_RETRIES=3, `target_alive` held constant -> three timeouts, two extra `trigger` pulses, then `boot_fail`=1 and `retry_count`=3. A later `reset_req` -> `retry_count`=0, `trigger` pulses.
- `reset_req` held high during POWER_WAIT/BOOT_WAIT -> no additional triggers until READY.
- With `TARGET_BOOT_WATCHDOG_EN`, WATCHDOG_CYCLES=8, heartbeat stops in READY -> `watchdog_bite` pulse after 8 edge-free cycles, then `trigger`. Without the macro -> stays READY indefinitely.
- Assert `rst` during BOOT_WAIT with `retry_count`=2 -> all outputs return to reset values next cycle.
